freq_meter: RTL and testbench

Measures the period and high time of a slow, asynchronous input signal, counted in system-clock cycles. It is the receive-side counterpart of the clock divider: it checks divided or external low-rate clocks against the reference clock. Each completed period is reported through a valid/ack result interface, with timeout and overrun flags. It sits beside the divider in the clock-monitoring path.

---
 rtl/clk_pkg.sv | 16 +
 rtl/sig_sync.sv | 40 ++++
 rtl/freq_meter.sv | 147 ++++++++++++++
 tb/tb_freq_meter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_pkg.sv
// Shared clock-monitoring types and defaults used by the divider and the frequency meter.
package clk_pkg;

  localparam int unsigned COUNTER_W     = 32;
  localparam int unsigned FREQUENCY_IN  = 10000;
  localparam int unsigned TIMEOUT_COUNT = 2 * FREQUENCY_IN;

  typedef logic [COUNTER_W-1:0] counter_t;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } meter_state_t;

endpackage

// File: rtl/sig_sync.sv
// Two-flop synchronizer plus edge register for an asynchronous control input.
// sync_level is delayed one extra stage so it lines up with the registered rise pulse.
module sig_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_level,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic level_q, level_d;
  logic rise_q, rise_d;

  always_comb begin
    meta_d  = async_in;
    sync_d  = meta_q;
    level_d = sync_q;
    rise_d  = sync_q & ~level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign sync_level = level_q;
  assign rise       = rise_q;

endmodule

// File: rtl/freq_meter.sv
// Measures period and high time of a slow asynchronous signal in clk cycles,
// reporting each completed period through a valid/ack result with overrun and timeout flags.
module freq_meter
  import clk_pkg::*;
#(
  parameter int unsigned FREQUENCY_IN  = clk_pkg::FREQUENCY_IN,
  parameter int unsigned TIMEOUT_COUNT = 2 * FREQUENCY_IN
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     enable,
  input  logic     sig_in,
  input  logic     meas_ack,
  output counter_t period,
  output counter_t high_time,
  output logic     meas_valid,
  output logic     overrun,
  output logic     timeout
);

  localparam counter_t TIMEOUT_LAST = counter_t'(TIMEOUT_COUNT - 1);

  logic sync_level;
  logic rise;

  meter_state_t state_q, state_d;
  counter_t     cnt_q, cnt_d;
  counter_t     hcnt_q, hcnt_d;
  counter_t     period_q, period_d;
  counter_t     high_q, high_d;
  logic         valid_q, valid_d;
  logic         overrun_q, overrun_d;
  logic         timeout_q, timeout_d;
  logic         enable_q, enable_d;
  logic         load_c;

  sig_sync u_sig_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (sig_in),
    .sync_level (sync_level),
    .rise       (rise)
  );

  // Next-state, counters, result registers and flags
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    enable_d  = enable;
    load_c    = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          hcnt_d  = '0;
          state_d = ARM;
        end
        ARM: begin
          cnt_d  = '0;
          hcnt_d = '0;
          if (rise) begin
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            load_c   = 1'b1;
            period_d = cnt_q + counter_t'(1);
            high_d   = hcnt_q + counter_t'(sync_level);
            cnt_d    = '0;
            hcnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            // Result registers are left alone; only the flag records the stall
            timeout_d = 1'b1;
            cnt_d     = '0;
            hcnt_d    = '0;
            state_d   = ARM;
          end else begin
            cnt_d = cnt_q + counter_t'(1);
            if (sync_level) begin
              hcnt_d = hcnt_q + counter_t'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // An ack landing with a load keeps valid set and overrun clear
    if (valid_q && meas_ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (load_c) begin
      valid_d = 1'b1;
      if (valid_q && !meas_ack) begin
        overrun_d = 1'b1;
      end
    end

    if (enable_q && !enable) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      enable_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      enable_q  <= enable_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = valid_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed scenario bench for freq_meter with hand-computed expected results.
module tb_freq_meter;
  import clk_pkg::*;

  localparam int unsigned T = 20000;

  logic     clk = 1'b0;
  logic     rst;
  logic     enable;
  logic     sig_in;
  logic     ack_auto = 1'b0;
  logic     ack_man;
  logic     meas_ack;
  counter_t period;
  counter_t high_time;
  logic     meas_valid;
  logic     overrun;
  logic     timeout;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  bit          auto_ack = 1'b0;
  logic [63:0] res_q[$];

  assign meas_ack = ack_auto | ack_man;

  always #5 clk = ~clk;

  freq_meter #(
    .FREQUENCY_IN  (10000),
    .TIMEOUT_COUNT (T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .sig_in     (sig_in),
    .meas_ack   (meas_ack),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  // Consumer that captures and acknowledges every valid result when enabled
  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack && meas_valid) begin
        res_q.push_back({period, high_time});
        ack_auto = 1'b1;
      end else begin
        ack_auto = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_wave(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      repeat (h) tick();
      sig_in = 1'b0;
      repeat (p - h) tick();
    end
  endtask

  task automatic begin_test();
    enable = 1'b1;
    tick();
    tick();
  endtask

  task automatic end_test();
    sig_in  = 1'b0;
    enable  = 1'b0;
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    repeat (6) tick();
    auto_ack = 1'b0;
    res_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_total++; if (period !== 32'd0) $display("FAIL reset_period: got %0d want 0", period); else n_pass++;
    n_total++; if (high_time !== 32'd0) $display("FAIL reset_high: got %0d want 0", high_time); else n_pass++;
    n_total++; if (meas_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", meas_valid); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else n_pass++;
    n_total++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_first_edge();
    begin_test();
    sig_in = 1'b1;
    repeat (5) tick();
    sig_in = 1'b0;
    repeat (20) tick();
    n_total++; if (meas_valid !== 1'b0) $display("FAIL first_edge_valid: got %b want 0", meas_valid); else n_pass++;
    end_test();
  endtask

  task automatic test_latency();
    begin_test();
    gen_wave(20, 5, 1);
    sig_in = 1'b1;
    repeat (3) tick();
    n_total++; if (meas_valid !== 1'b0) $display("FAIL latency_early: got %b want 0", meas_valid); else n_pass++;
    tick();
    n_total++; if (meas_valid !== 1'b1) $display("FAIL latency_valid: got %b want 1", meas_valid); else n_pass++;
    n_total++; if (period !== 32'd20) $display("FAIL latency_period: got %0d want 20", period); else n_pass++;
    n_total++; if (high_time !== 32'd5) $display("FAIL latency_high: got %0d want 5", high_time); else n_pass++;
    end_test();
  endtask

  task automatic test_nominal();
    auto_ack = 1'b1;
    begin_test();
    gen_wave(10000, 5000, 3);
    repeat (6) tick();
    n_total++; if (res_q.size() !== 2) $display("FAIL nominal_count: got %0d want 2", res_q.size()); else n_pass++;
    foreach (res_q[i]) begin
      n_total++; if (res_q[i][63:32] !== 32'd10000) $display("FAIL nominal_period: got %0d want 10000", res_q[i][63:32]); else n_pass++;
      n_total++; if (res_q[i][31:0] !== 32'd5000) $display("FAIL nominal_high: got %0d want 5000", res_q[i][31:0]); else n_pass++;
    end
    n_total++; if (overrun !== 1'b0) $display("FAIL nominal_overrun: got %b want 0", overrun); else n_pass++;
    n_total++; if (timeout !== 1'b0) $display("FAIL nominal_timeout: got %b want 0", timeout); else n_pass++;
    end_test();
  endtask

  task automatic test_duty();
    auto_ack = 1'b1;
    begin_test();
    gen_wave(7, 2, 4);
    repeat (6) tick();
    n_total++; if (res_q.size() !== 3) $display("FAIL duty_count: got %0d want 3", res_q.size()); else n_pass++;
    foreach (res_q[i]) begin
      n_total++; if (res_q[i][63:32] !== 32'd7) $display("FAIL duty_period: got %0d want 7", res_q[i][63:32]); else n_pass++;
      n_total++; if (res_q[i][31:0] !== 32'd2) $display("FAIL duty_high: got %0d want 2", res_q[i][31:0]); else n_pass++;
    end
    end_test();
    auto_ack = 1'b1;
    begin_test();
    gen_wave(2, 1, 5);
    repeat (6) tick();
    n_total++; if (res_q.size() !== 4) $display("FAIL minper_count: got %0d want 4", res_q.size()); else n_pass++;
    foreach (res_q[i]) begin
      n_total++; if (res_q[i][63:32] !== 32'd2) $display("FAIL minper_period: got %0d want 2", res_q[i][63:32]); else n_pass++;
      n_total++; if (res_q[i][31:0] !== 32'd1) $display("FAIL minper_high: got %0d want 1", res_q[i][31:0]); else n_pass++;
    end
    n_total++; if (overrun !== 1'b0) $display("FAIL minper_overrun: got %b want 0", overrun); else n_pass++;
    end_test();
  endtask

  task automatic test_overrun();
    begin_test();
    gen_wave(100, 30, 4);
    repeat (6) tick();
    n_total++; if (period !== 32'd100) $display("FAIL ovr_period: got %0d want 100", period); else n_pass++;
    n_total++; if (high_time !== 32'd30) $display("FAIL ovr_high: got %0d want 30", high_time); else n_pass++;
    n_total++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun); else n_pass++;
    n_total++; if (meas_valid !== 1'b1) $display("FAIL ovr_valid: got %b want 1", meas_valid); else n_pass++;
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    n_total++; if (meas_valid !== 1'b0) $display("FAIL ovr_ack_valid: got %b want 0", meas_valid); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL ovr_ack_flag: got %b want 0", overrun); else n_pass++;
    end_test();
    // Ack lands on the same edge as the next load
    begin_test();
    gen_wave(50, 10, 2);
    sig_in = 1'b1;
    repeat (3) tick();
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    n_total++; if (meas_valid !== 1'b1) $display("FAIL coack_valid: got %b want 1", meas_valid); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL coack_overrun: got %b want 0", overrun); else n_pass++;
    n_total++; if (period !== 32'd50) $display("FAIL coack_period: got %0d want 50", period); else n_pass++;
    n_total++; if (high_time !== 32'd10) $display("FAIL coack_high: got %0d want 10", high_time); else n_pass++;
    end_test();
  endtask

  task automatic test_timeout();
    begin_test();
    gen_wave(60, 20, 1);
    sig_in = 1'b1;
    repeat (20) tick();
    sig_in = 1'b0;
    repeat (T + 3 - 20) tick();
    n_total++; if (timeout !== 1'b0) $display("FAIL tmo_early: got %b want 0", timeout); else n_pass++;
    tick();
    n_total++; if (timeout !== 1'b1) $display("FAIL tmo_flag: got %b want 1", timeout); else n_pass++;
    n_total++; if (dut.state_q !== ARM) $display("FAIL tmo_state: got %0d want %0d", dut.state_q, ARM); else n_pass++;
    n_total++; if (period !== 32'd60) $display("FAIL tmo_period: got %0d want 60", period); else n_pass++;
    n_total++; if (high_time !== 32'd20) $display("FAIL tmo_high: got %0d want 20", high_time); else n_pass++;
    n_total++; if (meas_valid !== 1'b1) $display("FAIL tmo_valid: got %b want 1", meas_valid); else n_pass++;
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    gen_wave(40, 15, 2);
    n_total++; if (meas_valid !== 1'b1) $display("FAIL tmo_rearm_valid: got %b want 1", meas_valid); else n_pass++;
    n_total++; if (period !== 32'd40) $display("FAIL tmo_rearm_period: got %0d want 40", period); else n_pass++;
    n_total++; if (high_time !== 32'd15) $display("FAIL tmo_rearm_high: got %0d want 15", high_time); else n_pass++;
    n_total++; if (timeout !== 1'b1) $display("FAIL tmo_sticky: got %b want 1", timeout); else n_pass++;
    enable = 1'b0;
    tick();
    n_total++; if (timeout !== 1'b0) $display("FAIL tmo_clear: got %b want 0", timeout); else n_pass++;
    end_test();
  endtask

  task automatic test_enable_drop();
    begin_test();
    gen_wave(30, 10, 2);
    enable = 1'b0;
    repeat (2) tick();
    n_total++; if (meas_valid !== 1'b1) $display("FAIL en_keep_valid: got %b want 1", meas_valid); else n_pass++;
    n_total++; if (period !== 32'd30) $display("FAIL en_keep_period: got %0d want 30", period); else n_pass++;
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    enable = 1'b1;
    repeat (2) tick();
    gen_wave(30, 10, 1);
    n_total++; if (meas_valid !== 1'b0) $display("FAIL en_fresh_first: got %b want 0", meas_valid); else n_pass++;
    gen_wave(30, 10, 1);
    n_total++; if (meas_valid !== 1'b1) $display("FAIL en_fresh_valid: got %b want 1", meas_valid); else n_pass++;
    n_total++; if (period !== 32'd30) $display("FAIL en_fresh_period: got %0d want 30", period); else n_pass++;
    n_total++; if (high_time !== 32'd10) $display("FAIL en_fresh_high: got %0d want 10", high_time); else n_pass++;
    end_test();
  endtask

  task automatic test_async_reset();
    begin_test();
    gen_wave(30, 10, 2);
    n_total++; if (meas_valid !== 1'b1) $display("FAIL arst_pre_valid: got %b want 1", meas_valid); else n_pass++;
    sig_in = 1'b1;
    repeat (2) tick();
    #2;
    rst = 1'b1;
    #1;
    n_total++; if (period !== 32'd0) $display("FAIL arst_period: got %0d want 0", period); else n_pass++;
    n_total++; if (high_time !== 32'd0) $display("FAIL arst_high: got %0d want 0", high_time); else n_pass++;
    n_total++; if (meas_valid !== 1'b0) $display("FAIL arst_valid: got %b want 0", meas_valid); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL arst_overrun: got %b want 0", overrun); else n_pass++;
    n_total++; if (timeout !== 1'b0) $display("FAIL arst_timeout: got %b want 0", timeout); else n_pass++;
    tick();
    rst    = 1'b0;
    sig_in = 1'b0;
    repeat (10) tick();
    n_total++; if (meas_valid !== 1'b0) $display("FAIL arst_after_valid: got %b want 0", meas_valid); else n_pass++;
    end_test();
  endtask

  initial begin
    rst     = 1'b1;
    enable  = 1'b0;
    sig_in  = 1'b0;
    ack_man = 1'b0;
    test_reset();
    test_first_edge();
    test_latency();
    test_duty();
    test_overrun();
    test_enable_drop();
    test_async_reset();
    test_nominal();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
